seg7_scan_mux: RTL and testbench

Parametrised multiplexed 7-segment display driver: it time-multiplexes DIGITS hex or BCD nibbles onto one shared segment bus with a one-hot digit select. On top of the plain nibble-to-glyph decode it adds:
- a load-latched shadow register,
- leading-zero blanking,
- per-digit blink,
- a BCD/hex mode.

It sits between the datapath and the board's common-segment LED display and is the standard display front end for all lab top levels.

---
 rtl/seg7_scan_mux_if.sv | 31 +++
 rtl/seg7_scan_mux.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_mux_if
// Brief   : Display bus between the datapath and the 7-segment scan driver.
// Revision: 1.0
// ============================================================================
interface seg7_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blink_en;
    logic                  blank_lz;
    logic                  bcd_mode;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     dig_sel;
    logic                  frame_tick;

    modport master (
        output load, din, dp_in, blink_en, blank_lz, bcd_mode,
        input  seg, dp, dig_sel, frame_tick
    );

    modport slave (
        input  load, din, dp_in, blink_en, blank_lz, bcd_mode,
        output seg, dp, dig_sel, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_mux
// Brief   : Multiplexed 7-segment driver with shadow load, LZ blanking, blink.
// Revision: 1.0
// ============================================================================
module seg7_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seg7_scan_mux_if.slave   bus
);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]  c_DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [FCNT_W-1:0] c_FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] c_ONE       = DIGITS'(1);

    logic [4*DIGITS-1:0] r_sh_din;
    logic [DIGITS-1:0]   r_sh_dp;
    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [FCNT_W-1:0]   r_fcnt;
    logic                r_vis;

    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig_sel;
    logic                r_frame_tick;

    logic                w_div_tc;
    logic                w_wrap;
    logic [3:0]          w_nib;
    logic                w_dp_sel;
    logic                w_blink_sel;
    logic                w_lz_sel;
    logic                w_zero_above;
    logic [6:0]          w_glyph;

    assign w_div_tc = (r_div == c_DIV_LAST);
    assign w_wrap   = w_div_tc && (r_idx == c_IDX_LAST);

    // Walk from the top digit down so w_zero_above covers nibbles i..DIGITS-1.
    always_comb begin
        w_nib        = 4'd0;
        w_dp_sel     = 1'b0;
        w_blink_sel  = 1'b0;
        w_lz_sel     = 1'b0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_sh_din[4*i +: 4] == 4'd0);
            if (IDX_W'(i) == r_idx) begin
                w_nib       = r_sh_din[4*i +: 4];
                w_dp_sel    = r_sh_dp[i];
                w_blink_sel = bus.blink_en[i];
                w_lz_sel    = (i > 0) && w_zero_above;
            end
        end
    end

    always_comb begin
        w_glyph = 7'h00;
        case (w_nib)
            4'h0:    w_glyph = 7'h7E;
            4'h1:    w_glyph = 7'h30;
            4'h2:    w_glyph = 7'h6D;
            4'h3:    w_glyph = 7'h79;
            4'h4:    w_glyph = 7'h33;
            4'h5:    w_glyph = 7'h5B;
            4'h6:    w_glyph = 7'h5F;
            4'h7:    w_glyph = 7'h70;
            4'h8:    w_glyph = 7'h7F;
            4'h9:    w_glyph = 7'h7B;
            4'hA:    w_glyph = 7'h77;
            4'hB:    w_glyph = 7'h1F;
            4'hC:    w_glyph = 7'h4E;
            4'hD:    w_glyph = 7'h3D;
            4'hE:    w_glyph = 7'h4F;
            default: w_glyph = 7'h47;
        endcase
        if (bus.bcd_mode && (w_nib > 4'd9)) begin
            w_glyph = 7'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_din     <= '0;
            r_sh_dp      <= '0;
            r_div        <= '0;
            r_idx        <= '0;
            r_fcnt       <= '0;
            r_vis        <= 1'b1;
            r_seg        <= 7'h00;
            r_dp         <= 1'b0;
            r_dig_sel    <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (bus.load) begin
                r_sh_din <= bus.din;
                r_sh_dp  <= bus.dp_in;
            end

            if (w_div_tc) begin
                r_div <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            r_frame_tick <= w_wrap;
            if (w_wrap) begin
                if (r_fcnt == c_FCNT_LAST) begin
                    r_fcnt <= '0;
                    r_vis  <= ~r_vis;
                end else begin
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end
            end

            // A blinked-off slot keeps its dwell but drives nothing.
            if (w_blink_sel && !r_vis) begin
                r_seg     <= 7'h00;
                r_dp      <= 1'b0;
                r_dig_sel <= '0;
            end else begin
                r_seg     <= (bus.blank_lz && w_lz_sel) ? 7'h00 : w_glyph;
                r_dp      <= w_dp_sel;
                r_dig_sel <= c_ONE << r_idx;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_mux
// Brief   : Randomized self-checking bench with a time-based reference model.
// Revision: 1.0
// ============================================================================
module tb_seg7_scan_mux;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    seg7_scan_mux_if #(.DIGITS(D)) bus ();

    seg7_scan_mux #(
        .DIGITS       (D),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit [6:0] glyph [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model state: edges since reset release and the shadowed display contents.
    int       m_n;
    bit [3:0] m_sh [D];
    bit [D-1:0] m_dp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    task automatic step();
        int         idx;
        int         frame;
        bit         vis;
        bit         blanked;
        bit [3:0]   nib;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [D-1:0] e_sel;
        logic       e_ft;
        logic       l_rst_n;
        logic       l_load;
        logic [4*D-1:0] l_din;
        logic [D-1:0]   l_dpin;

        l_rst_n = rst_n;
        l_load  = bus.load;
        l_din   = bus.din;
        l_dpin  = bus.dp_in;
        e_seg = 7'h00; e_dp = 1'b0; e_sel = '0; e_ft = 1'b0;

        if (l_rst_n) begin
            idx   = (m_n / SD) % D;
            frame = m_n / (SD * D);
            vis   = ((frame / BF) % 2) == 0;
            e_ft  = ((m_n + 1) % (SD * D)) == 0;
            if (!(bus.blink_en[idx] && !vis)) begin
                nib   = m_sh[idx];
                e_seg = (bus.bcd_mode && nib > 9) ? 7'h01 : glyph[nib];
                blanked = 1'b0;
                if (bus.blank_lz && idx > 0) begin
                    blanked = 1'b1;
                    for (int j = idx; j < D; j++) if (m_sh[j] != 0) blanked = 1'b0;
                end
                if (blanked) e_seg = 7'h00;
                e_dp  = m_dp[idx];
                e_sel = D'(1) << idx;
            end
        end

        @(posedge clk);
        #1;
        chk("seg",        32'(bus.seg),        32'(e_seg));
        chk("dp",         32'(bus.dp),         32'(e_dp));
        chk("dig_sel",    32'(bus.dig_sel),    32'(e_sel));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e_ft));
        chk("onehot",     32'($countones(bus.dig_sel) <= 1), 32'(1));

        if (!l_rst_n) begin
            m_n = 0;
            for (int j = 0; j < D; j++) m_sh[j] = 4'h0;
            m_dp = '0;
        end else begin
            m_n++;
            if (l_load) begin
                for (int j = 0; j < D; j++) m_sh[j] = l_din[4*j +: 4];
                m_dp = l_dpin;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic load_pulse(input logic [4*D-1:0] v, input logic [D-1:0] p);
        bus.din = v; bus.dp_in = p; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; m_n = 0; m_dp = '0;
        for (int j = 0; j < D; j++) m_sh[j] = 4'h0;
        rst_n = 1'b0;
        bus.load = 1'b0; bus.din = '0; bus.dp_in = '0; bus.blink_en = '0;
        bus.blank_lz = 1'b0; bus.bcd_mode = 1'b0;
        @(negedge clk);

        // Reset and basic scan
        run(3);
        rst_n = 1'b1;
        load_pulse(16'h1234, 4'b0000);
        run(40);

        // Hex vs BCD
        load_pulse(16'hABCF, 4'b0101);
        run(20);
        bus.bcd_mode = 1'b1;
        run(20);
        bus.bcd_mode = 1'b0;

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        load_pulse(16'h0050, 4'b1000);
        run(20);
        load_pulse(16'h0000, 4'b0000);
        run(20);
        bus.blank_lz = 1'b0;

        // Blink across six frames from a fresh reset
        rst_n = 1'b0; step(); rst_n = 1'b1;
        load_pulse(16'h1234, 4'b0000);
        bus.blink_en = 4'b0010;
        run(100);
        bus.blink_en = '0;

        // Load timing: din moves without load, then a single-cycle load
        bus.din = 16'h9999;
        run(6);
        load_pulse(16'h5678, 4'b0001);
        bus.din = 16'h0000;
        run(10);
        bus.load = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.din = 16'($urandom);
            step();
        end
        bus.load = 1'b0;

        // Reset mid-frame during digit 2
        while (((m_n / SD) % D) != 2) step();
        step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        run(20);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.din      = 16'($urandom);
            if ($urandom_range(0, 1) == 0) bus.din[15:8] = 8'h00;
            bus.dp_in    = 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.blink_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.blank_lz = 1'($urandom);
            if ($urandom_range(0, 31) == 0) bus.bcd_mode = 1'($urandom);
            rst_n        = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
